// File: rtl/me_sched.sv
// me_sched: sequencer and minimum-distance selector for a row of
// absolute-difference PEs. PE k runs k cycles behind PE0, so every
// per-PE control and capture strobe is a k-cycle delayed copy of the
// PE0 version.
module me_sched #(
  parameter int NPE  = 4,
  parameter int BLK  = 4,
  parameter int NGRP = 4,
  localparam int P     = BLK * BLK,
  localparam int NCAND = NPE * NGRP,
  localparam int PW    = (P > 1) ? $clog2(P) : 1,
  localparam int GW    = (NGRP > 1) ? $clog2(NGRP) : 1,
  localparam int CW    = (NCAND > 1) ? $clog2(NCAND) : 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [NPE*8-1:0] acc_in,
  output logic [NPE-1:0]   pe_newdist,
  output logic [NPE-1:0]   pe_s1s2mux,
  output logic [PW-1:0]    addr_r,
  output logic [GW-1:0]    grp_idx,
  output logic             busy,
  output logic             done,
  output logic [7:0]       best_dist,
  output logic [CW-1:0]    best_mv
);

  localparam int DW = (NPE > 1) ? $clog2(NPE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  pix_q, pix_d;
  logic [GW-1:0]  grp_q, grp_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic [NPE-1:0] nd_q, nd_d;
  logic [NPE-1:0] mux_q, mux_d;
  logic [NPE-1:0] cap_q, cap_d;
  logic [GW-1:0]  cg_q [NPE];
  logic [GW-1:0]  cg_d [NPE];
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [7:0]     best_dist_q, best_dist_d;
  logic [CW-1:0]  best_mv_q, best_mv_d;
  logic           cap0;

  // Sequencer: state, pixel/group counters, drain counter; cap0 marks a group's PE0 end
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    grp_d   = grp_q;
    drain_d = drain_q;
    cap0    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pix_d   = '0;
          grp_d   = '0;
        end
      end
      S_RUN: begin
        if (pix_q == PW'(P - 1)) begin
          pix_d = '0;
          cap0  = 1'b1;
          if (grp_q == GW'(NGRP - 1)) begin
            state_d = S_DRAIN;
            grp_d   = '0;
            drain_d = '0;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DW'(NPE - 1)) state_d = S_DONE;
        else drain_d = drain_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-PE controls: PE0 values from the next state, PE k is PE k-1 one cycle later
  always_comb begin
    nd_d[0]  = (state_d == S_RUN) && (pix_d == '0);
    mux_d[0] = (state_d == S_RUN) && !grp_d[0];
    cap_d[0] = cap0;
    cg_d[0]  = grp_q;
    for (int k = 1; k < NPE; k++) begin
      nd_d[k]  = nd_q[k-1];
      mux_d[k] = mux_q[k-1];
      cap_d[k] = cap_q[k-1];
      cg_d[k]  = cg_q[k-1];
    end
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // Minimum tracking: first capture of a search loads, later ones replace on strict less-than
  always_comb begin
    best_dist_d = best_dist_q;
    best_mv_d   = best_mv_q;
    for (int k = 0; k < NPE; k++) begin
      if (cap_q[k] && (((k == 0) && (cg_q[k] == '0)) || (acc_in[8*k +: 8] < best_dist_d))) begin
        best_dist_d = acc_in[8*k +: 8];
        best_mv_d   = CW'(int'(cg_q[k]) * NPE + k);
      end
    end
  end

  // All state and registered outputs; reset clears delay lines and aborts a search
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      pix_q       <= '0;
      grp_q       <= '0;
      drain_q     <= '0;
      nd_q        <= '0;
      mux_q       <= '0;
      cap_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      best_dist_q <= '0;
      best_mv_q   <= '0;
      for (int k = 0; k < NPE; k++) cg_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      grp_q       <= grp_d;
      drain_q     <= drain_d;
      nd_q        <= nd_d;
      mux_q       <= mux_d;
      cap_q       <= cap_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      best_dist_q <= best_dist_d;
      best_mv_q   <= best_mv_d;
      for (int k = 0; k < NPE; k++) cg_q[k] <= cg_d[k];
    end
  end

  assign pe_newdist = nd_q;
  assign pe_s1s2mux = mux_q;
  assign addr_r     = pix_q;
  assign grp_idx    = grp_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign best_dist  = best_dist_q;
  assign best_mv    = best_mv_q;

endmodule

// File: tb/tb_me_sched.sv
// Testbench for me_sched: a PE row model fed by a candidate memory model,
// a table of distance patterns, and hand-written start/reset sequences.
module tb_me_sched;
  localparam int NPE = 4, BLK = 4, NGRP = 4, P = 16, NCAND = 16;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             start = 1'b0;
  logic [NPE*8-1:0] acc_in;
  logic [NPE-1:0]   pe_newdist, pe_s1s2mux;
  logic [3:0]       addr_r;
  logic [1:0]       grp_idx;
  logic             busy, done;
  logic [7:0]       best_dist;
  logic [3:0]       best_mv;

  me_sched #(.NPE(NPE), .BLK(BLK), .NGRP(NGRP)) dut (
    .clock(clock), .resetn(resetn), .start(start), .acc_in(acc_in),
    .pe_newdist(pe_newdist), .pe_s1s2mux(pe_s1s2mux), .addr_r(addr_r),
    .grp_idx(grp_idx), .busy(busy), .done(done),
    .best_dist(best_dist), .best_mv(best_mv)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Candidate memory: total distance per candidate; >255 means saturating pixels
  int dist_m [NCAND];

  function automatic int contrib(int c, int p);
    if (dist_m[c] > 255) return 20;
    return dist_m[c] / P + ((p < dist_m[c] % P) ? 1 : 0);
  endfunction

  // PE row model: PE k sees addr_r/grp_idx delayed k cycles, newDist restarts the sum
  logic [7:0] acc_m [NPE];
  int ah [NPE];
  int gh [NPE];
  always @(posedge clock) begin
    int p, g, s;
    for (int k = 0; k < NPE; k++) begin
      p = (k == 0) ? int'(addr_r) : ah[(k == 0) ? 0 : k - 1];
      g = (k == 0) ? int'(grp_idx) : gh[(k == 0) ? 0 : k - 1];
      s = contrib(g * NPE + k, p);
      if (!pe_newdist[k]) s = s + int'(acc_m[k]);
      acc_m[k] <= (s > 255) ? 8'hFF : 8'(s);
    end
    ah[0] <= int'(addr_r);
    gh[0] <= int'(grp_idx);
    for (int j = 1; j < NPE; j++) begin
      ah[j] <= ah[j-1];
      gh[j] <= gh[j-1];
    end
  end

  always_comb begin
    acc_in = '0;
    for (int k = 0; k < NPE; k++) acc_in[8*k +: 8] = acc_m[k];
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected control timing relative to the start-sampling cycle (cycle 0)
  function automatic int exp_nd(int r);
    int v = 0;
    for (int k = 0; k < NPE; k++) begin
      int d = r - 1 - k;
      if (d >= 0 && d < NGRP * P && (d % P) == 0) v = v | (1 << k);
    end
    return v;
  endfunction

  function automatic int exp_mux(int r);
    int v = 0;
    for (int k = 0; k < NPE; k++) begin
      int d = r - 1 - k;
      if (d >= 0 && d < NGRP * P && ((d / P) % 2) == 0) v = v | (1 << k);
    end
    return v;
  endfunction

  function automatic int exp_addr(int r);
    return (r >= 1 && r <= NGRP * P) ? (r - 1) % P : 0;
  endfunction

  function automatic int exp_grp(int r);
    return (r >= 1 && r <= NGRP * P) ? (r - 1) / P : 0;
  endfunction

  int nd_h [256];
  int mux_h [256];
  int addr_h [256];
  int grp_h [256];

  typedef struct {
    int ca; int da; int cb; int db; int base; int mid; int exp_d; int exp_mv;
  } vec_t;
  vec_t vecs [8];

  task automatic fill(input vec_t v);
    for (int c = 0; c < NCAND; c++) dist_m[c] = v.base;
    dist_m[v.ca] = v.da;
    dist_m[v.cb] = v.db;
  endtask

  // One search: start pulse, optional stray start at cycle 'mid', record controls until done
  task automatic run_search(input int mid, output int done_rel, output int busy_cnt);
    int t0, r;
    done_rel = -1;
    busy_cnt = 0;
    @(negedge clock);
    start = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      r = cyc - t0;
      start = (r == mid);
      if (busy) busy_cnt++;
      nd_h[r] = int'(pe_newdist);
      mux_h[r] = int'(pe_s1s2mux);
      addr_h[r] = int'(addr_r);
      grp_h[r] = int'(grp_idx);
      if (done) begin
        done_rel = r;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic verify(input string tag, input int done_rel, input int busy_cnt,
                        input int exp_d, input int exp_mv);
    int errs = 0;
    int last = (done_rel < 0) ? 200 : done_rel;
    for (int r = 1; r <= last; r++) begin
      if (nd_h[r] != exp_nd(r) || mux_h[r] != exp_mux(r) ||
          addr_h[r] != exp_addr(r) || grp_h[r] != exp_grp(r)) errs++;
    end
    chk({tag, " done_cycle"}, done_rel, 69);
    chk({tag, " busy_cycles"}, busy_cnt, 68);
    chk({tag, " ctrl_seq_errs"}, errs, 0);
    chk({tag, " best_dist"}, int'(best_dist), exp_d);
    chk({tag, " best_mv"}, int'(best_mv), exp_mv);
    $display("%s: done@%0d busy=%0d best_dist=0x%0h best_mv=%0d", tag, done_rel, busy_cnt,
             best_dist, best_mv);
    @(negedge clock);
    chk({tag, " done_one_cycle"}, int'(done), 0);
    chk({tag, " best_dist_held"}, int'(best_dist), exp_d);
  endtask

  function automatic int all_outs();
    return int'({pe_newdist, pe_s1s2mux, addr_r, grp_idx, busy, done, best_dist, best_mv});
  endfunction

  initial begin
    int dr, bc, t0, r, d1, d2, b70, b71, dcount;

    vecs[0] = '{9, 3, 9, 3, 10, -1, 3, 9};
    vecs[1] = '{5, 0, 12, 0, 50, -1, 0, 5};
    vecs[2] = '{0, 300, 0, 300, 300, -1, 255, 0};
    vecs[3] = '{10, 254, 3, 300, 300, -1, 254, 10};
    vecs[4] = '{0, 7, 0, 7, 7, -1, 7, 0};
    vecs[5] = '{0, 1, 3, 1, 20, -1, 1, 0};
    vecs[6] = '{7, 5, 8, 4, 200, 20, 4, 8};
    vecs[7] = '{15, 99, 0, 200, 100, -1, 99, 15};

    // Reset state
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_outputs", all_outs(), 0);
    resetn = 1'b1;
    @(negedge clock);
    chk("idle_busy", int'(busy), 0);

    // Table of distance patterns
    for (int i = 0; i < 8; i++) begin
      fill(vecs[i]);
      run_search(vecs[i].mid, dr, bc);
      if (i == 0) begin
        chk("mux2_c3", (mux_h[3] >> 2) & 1, 1);
        chk("mux2_c18", (mux_h[18] >> 2) & 1, 1);
        chk("mux2_c19", (mux_h[19] >> 2) & 1, 0);
        chk("mux2_c34", (mux_h[34] >> 2) & 1, 0);
        chk("mux2_c35", (mux_h[35] >> 2) & 1, 1);
        chk("mux2_c50", (mux_h[50] >> 2) & 1, 1);
        chk("addr_c16", addr_h[16], 15);
        chk("addr_wrap_c17", addr_h[17], 0);
        chk("grp_inc_c17", grp_h[17], 1);
        chk("nd3_c52", (nd_h[52] >> 3) & 1, 1);
      end
      verify($sformatf("vec%0d", i), dr, bc, vecs[i].exp_d, vecs[i].exp_mv);
    end

    // Reset at cycle 30 aborts the search with no done
    fill(vecs[1]);
    @(negedge clock);
    start = 1'b1;
    t0 = cyc;
    dcount = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clock);
      r = cyc - t0;
      start = 1'b0;
      if (done) dcount++;
      if (r == 30) begin
        chk("pre_reset_busy", int'(busy), 1);
        resetn = 1'b0;
      end
      if (r == 31) begin
        chk("abort_outputs", all_outs(), 0);
        resetn = 1'b1;
      end
    end
    chk("abort_no_done", dcount, 0);
    $display("reset abort: done pulses=%0d", dcount);
    fill(vecs[5]);
    run_search(-1, dr, bc);
    verify("after_reset", dr, bc, vecs[5].exp_d, vecs[5].exp_mv);

    // start held high: second search begins only after DONE
    fill(vecs[0]);
    @(negedge clock);
    start = 1'b1;
    t0 = cyc;
    d1 = -1; d2 = -1; b70 = -1; b71 = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      r = cyc - t0;
      if (r == 70) b70 = int'(busy);
      if (r == 71) b71 = int'(busy);
      if (done) begin
        if (d1 < 0) d1 = r;
        else begin
          d2 = r;
          break;
        end
      end
    end
    start = 1'b0;
    chk("hold_done1", d1, 69);
    chk("hold_busy_c70", b70, 0);
    chk("hold_busy_c71", b71, 1);
    chk("hold_done2", d2, 139);
    chk("hold_best_dist", int'(best_dist), 3);
    chk("hold_best_mv", int'(best_mv), 9);
    $display("start held: done@%0d and @%0d best_dist=0x%0h best_mv=%0d", d1, d2, best_dist,
             best_mv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
